// File: rtl/onehot_pkg.sv
// Shared types and helpers for the one-hot stream encoder and its argmax counterpart.
// Holds the encoder state type, the default element values and the index-width function.
package onehot_pkg;

    typedef enum logic {
        IDLE,
        EMIT
    } enc_state_t;

    localparam int DEF_ON_VAL  = 1;
    localparam int DEF_OFF_VAL = 0;

    // Index/counter width for a vector of 'values' classes; never narrower than one bit.
    function automatic int CNT_W(input int values);
        return (values > 2) ? $clog2(values) : 1;
    endfunction

endpackage

// File: rtl/onehot_stream_encoder.sv
// Turns one class index per handshake into a serial one-hot vector of VALUES signed elements.
// Outputs come only from registered state, so there is no path from in_* to out_*.
module onehot_stream_encoder
    import onehot_pkg::*;
#(
    parameter int VALUES    = 3,
    parameter int DATA_SIZE = 8,
    parameter int ON_VAL    = DEF_ON_VAL,
    parameter int OFF_VAL   = DEF_OFF_VAL
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CNT_W(VALUES)-1:0]     in_index,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_SIZE-1:0]  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         err
);

    localparam int CW = CNT_W(VALUES);
    localparam logic [CW-1:0] LAST_CNT = CW'(VALUES - 1);
    localparam logic signed [DATA_SIZE-1:0] ON_D  = DATA_SIZE'(ON_VAL);
    localparam logic signed [DATA_SIZE-1:0] OFF_D = DATA_SIZE'(OFF_VAL);

    enc_state_t     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic           err_q, err_d;

    logic lastBeat;
    logic accept;
    logic outOfRange;

    // The extra bit lets VALUES itself be represented when VALUES is a power of two.
    assign outOfRange = ({1'b0, in_index} >= (CW + 1)'(VALUES));
    assign lastBeat   = (state_q == EMIT) && (cnt_q == LAST_CNT);
    assign in_ready   = (state_q == IDLE) || (lastBeat && out_ready);
    assign accept     = in_valid && in_ready;
    assign err_d      = accept && outOfRange;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // An accepted last beat either chains straight into the next index or falls back to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EMIT;
                    cnt_d   = '0;
                    idx_d   = in_index;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (lastBeat) begin
                        cnt_d = '0;
                        if (accept) begin
                            idx_d = in_index;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // An out-of-range index can never equal cnt, so its vector comes out all OFF_VAL.
    assign out_valid = (state_q == EMIT);
    assign out_last  = lastBeat;
    assign out_data  = (out_valid && (cnt_q == idx_q)) ? ON_D : OFF_D;
    assign err       = err_q;

endmodule

// File: tb/tb_onehot_stream_encoder.sv
// Self-checking bench for onehot_stream_encoder with three parameterisations sharing one clock.
// A beat-queue scoreboard and an argmax loopback supply the expected behaviour.
module tb_onehot_stream_encoder;

    typedef struct {
        logic signed [7:0] data;
        logic              last;
    } beat_t;

    localparam logic signed [7:0] B_OFF = -8'sd5;

    logic clk = 1'b0;
    logic rst_n;

    logic [1:0]        aIdx;
    logic              aInValid, aInReady, aOutValid, aOutReady, aLast, aErr;
    logic signed [7:0] aData;

    logic [1:0]        bIdx;
    logic              bInValid, bInReady, bOutValid, bOutReady, bLast, bErr;
    logic signed [7:0] bData;

    logic [2:0]        cIdx;
    logic              cInValid, cInReady, cOutValid, cOutReady, cLast, cErr;
    logic signed [7:0] cData;

    int    tests = 0;
    int    fails = 0;
    beat_t bQ[$];
    logic  bErrExp = 1'b0;

    always #5 clk = ~clk;

    onehot_stream_encoder #(.VALUES(3), .DATA_SIZE(8), .ON_VAL(1), .OFF_VAL(0)) uA (
        .clk(clk), .rst_n(rst_n), .in_index(aIdx), .in_valid(aInValid), .in_ready(aInReady),
        .out_data(aData), .out_valid(aOutValid), .out_ready(aOutReady), .out_last(aLast), .err(aErr)
    );

    onehot_stream_encoder #(.VALUES(3), .DATA_SIZE(8), .ON_VAL(100), .OFF_VAL(-5)) uB (
        .clk(clk), .rst_n(rst_n), .in_index(bIdx), .in_valid(bInValid), .in_ready(bInReady),
        .out_data(bData), .out_valid(bOutValid), .out_ready(bOutReady), .out_last(bLast), .err(bErr)
    );

    onehot_stream_encoder #(.VALUES(5), .DATA_SIZE(8), .ON_VAL(1), .OFF_VAL(0)) uC (
        .clk(clk), .rst_n(rst_n), .in_index(cIdx), .in_valid(cInValid), .in_ready(cInReady),
        .out_data(cData), .out_valid(cOutValid), .out_ready(cOutReady), .out_last(cLast), .err(cErr)
    );

    // Element k of the one-hot vector for class idx.
    function automatic logic signed [7:0] elemOf(input int idx, input int k, input int onV, input int offV);
        return (k == idx) ? 8'(onV) : 8'(offV);
    endfunction

    // One cycle on instance B: drive inputs, compare against the beat queue, then advance the queue.
    task automatic applyStimulus(input logic v, input logic [1:0] idx, input logic r);
        int    pending;
        logic  expReady;
        beat_t b;
        bInValid  = v;
        bIdx      = idx;
        bOutReady = r;
        @(negedge clk);
        pending  = bQ.size();
        expReady = (pending == 0) || (pending == 1 && r);
        tests++;
        if (bOutValid !== (pending > 0)) begin
            fails++;
            $display("[TB] FAIL b_out_valid t=%0t: got %b want %b", $time, bOutValid, (pending > 0));
        end
        tests++;
        if (bInReady !== expReady) begin
            fails++;
            $display("[TB] FAIL b_in_ready t=%0t: got %b want %b", $time, bInReady, expReady);
        end
        tests++;
        if (bErr !== bErrExp) begin
            fails++;
            $display("[TB] FAIL b_err t=%0t: got %b want %b", $time, bErr, bErrExp);
        end
        if (pending > 0) begin
            b = bQ[0];
            tests++;
            if (bData !== b.data) begin
                fails++;
                $display("[TB] FAIL b_data t=%0t: got %0d want %0d", $time, bData, b.data);
            end
            tests++;
            if (bLast !== b.last) begin
                fails++;
                $display("[TB] FAIL b_last t=%0t: got %b want %b", $time, bLast, b.last);
            end
        end else begin
            tests++;
            if (bData !== B_OFF || bLast !== 1'b0) begin
                fails++;
                $display("[TB] FAIL b_idle_out t=%0t: got %0d/%b want %0d/0", $time, bData, bLast, B_OFF);
            end
        end
        if (pending > 0 && r) b = bQ.pop_front();
        bErrExp = 1'b0;
        if (v && expReady) begin
            for (int k = 0; k < 3; k++) bQ.push_back('{elemOf(int'(idx), k, 100, -5), (k == 2)});
            bErrExp = (idx >= 2'd3);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        aInValid = 1'b0; aIdx = '0; aOutReady = 1'b0;
        bInValid = 1'b0; bIdx = '0; bOutReady = 1'b0;
        cInValid = 1'b0; cIdx = '0; cOutReady = 1'b0;
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (aOutValid !== 1'b0 || aLast !== 1'b0 || aErr !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_a_flags: got valid=%b last=%b err=%b want 0/0/0", aOutValid, aLast, aErr);
        end
        tests++;
        if (aInReady !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_a_in_ready: got %b want 1", aInReady);
        end
        tests++;
        if (aData !== 8'sd0) begin
            fails++;
            $display("[TB] FAIL reset_a_data: got %0d want 0", aData);
        end
        tests++;
        if (bData !== B_OFF) begin
            fails++;
            $display("[TB] FAIL reset_b_data: got %0d want %0d", bData, B_OFF);
        end
        tests++;
        if (cOutValid !== 1'b0 || cInReady !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_c: got valid=%b ready=%b want 0/1", cOutValid, cInReady);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // A single isolated vector on instance A with out_ready held high.
    task automatic test_single(input int idx);
        aIdx = 2'(idx);
        aInValid = 1'b1;
        aOutReady = 1'b1;
        @(negedge clk);
        tests++;
        if (aInReady !== 1'b1 || aOutValid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_accept idx=%0d: got ready=%b valid=%b want 1/0", idx, aInReady, aOutValid);
        end
        @(posedge clk);
        #1 aInValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if (aOutValid !== 1'b1 || aData !== elemOf(idx, k, 1, 0)) begin
                fails++;
                $display("[TB] FAIL single_beat idx=%0d k=%0d: got v=%b d=%0d want 1/%0d", idx, k, aOutValid, aData, elemOf(idx, k, 1, 0));
            end
            tests++;
            if (aLast !== (k == 2) || aInReady !== (k == 2)) begin
                fails++;
                $display("[TB] FAIL single_last idx=%0d k=%0d: got last=%b ready=%b want %b", idx, k, aLast, aInReady, (k == 2));
            end
            tests++;
            if (aErr !== (k == 0 && idx >= 3)) begin
                fails++;
                $display("[TB] FAIL single_err idx=%0d k=%0d: got %b want %b", idx, k, aErr, (k == 0 && idx >= 3));
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        tests++;
        if (aOutValid !== 1'b0 || aErr !== 1'b0 || aInReady !== 1'b1) begin
            fails++;
            $display("[TB] FAIL single_idle idx=%0d: got v=%b err=%b ready=%b want 0/0/1", idx, aOutValid, aErr, aInReady);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int idxs[2] = '{2, 0};
        aIdx = 2'(idxs[0]);
        aInValid = 1'b1;
        aOutReady = 1'b1;
        @(negedge clk);
        tests++;
        if (aInReady !== 1'b1) begin
            fails++;
            $display("[TB] FAIL b2b_first_ready: got %b want 1", aInReady);
        end
        @(posedge clk);
        #1 aIdx = 2'(idxs[1]);
        for (int v = 0; v < 2; v++) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                tests++;
                if (aOutValid !== 1'b1 || aData !== elemOf(idxs[v], k, 1, 0) || aLast !== (k == 2)) begin
                    fails++;
                    $display("[TB] FAIL b2b_beat v=%0d k=%0d: got v=%b d=%0d l=%b want 1/%0d/%b", v, k, aOutValid, aData, aLast, elemOf(idxs[v], k, 1, 0), (k == 2));
                end
                tests++;
                if (aInReady !== (k == 2)) begin
                    fails++;
                    $display("[TB] FAIL b2b_in_ready v=%0d k=%0d: got %b want %b", v, k, aInReady, (k == 2));
                end
                @(posedge clk);
                #1;
                if (v == 0 && k == 2) aInValid = 1'b0;
            end
        end
        @(negedge clk);
        tests++;
        if (aOutValid !== 1'b0 || aInReady !== 1'b1) begin
            fails++;
            $display("[TB] FAIL b2b_idle: got v=%b ready=%b want 0/1", aOutValid, aInReady);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        logic pattern[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        applyStimulus(1'b1, 2'd0, 1'b1);
        foreach (pattern[i]) applyStimulus(1'b0, 2'd0, pattern[i]);
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            applyStimulus(1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));
        end
        for (int n = 0; n < 12 && bQ.size() > 0; n++) applyStimulus(1'b0, 2'd0, 1'b1);
        applyStimulus(1'b0, 2'd0, 1'b1);
        tests++;
        if (bQ.size() != 0) begin
            fails++;
            $display("[TB] FAIL random_drain: got %0d beats pending want 0", bQ.size());
        end
    endtask

    task automatic test_loopback();
        logic signed [7:0] vec[5];
        int best;
        for (int i = 0; i < 5; i++) begin
            cIdx = 3'(i);
            cInValid = 1'b1;
            cOutReady = 1'b1;
            @(negedge clk);
            tests++;
            if (cInReady !== 1'b1) begin
                fails++;
                $display("[TB] FAIL loop_ready i=%0d: got %b want 1", i, cInReady);
            end
            @(posedge clk);
            #1 cInValid = 1'b0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                vec[k] = cData;
                tests++;
                if (cOutValid !== 1'b1 || cLast !== (k == 4)) begin
                    fails++;
                    $display("[TB] FAIL loop_beat i=%0d k=%0d: got v=%b l=%b want 1/%b", i, k, cOutValid, cLast, (k == 4));
                end
                @(posedge clk);
                #1;
            end
            best = 0;
            for (int k = 1; k < 5; k++) if (vec[k] > vec[best]) best = k;
            tests++;
            if (best != i) begin
                fails++;
                $display("[TB] FAIL loop_argmax: got %0d want %0d", best, i);
            end
        end
    endtask

    task automatic test_reset_mid_vector();
        aIdx = 2'd1;
        aInValid = 1'b1;
        aOutReady = 1'b1;
        @(posedge clk);
        #1 aInValid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if (aData !== 8'sd1) begin
            fails++;
            $display("[TB] FAIL midrst_beat1: got %0d want 1", aData);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (aOutValid !== 1'b0 || aInReady !== 1'b1 || aLast !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midrst_abort: got v=%b ready=%b last=%b want 0/1/0", aOutValid, aInReady, aLast);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        test_single(2);
    endtask

    initial begin
        test_reset();
        test_single(1);
        test_single(3);
        test_back_to_back();
        test_stall();
        test_random();
        test_loopback();
        test_reset_mid_vector();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/onehot_stream_encoder.md
# onehot_stream_encoder

- Converts a class index into a serial one-hot score vector; the inverse of the team's argmax (score-vector-to-index) block.
- Accepts one index per valid/ready handshake and emits `VALUES` signed elements over a valid/ready/last stream.
- Element `k` carries `ON_VAL` when `k` equals the index and `OFF_VAL` otherwise.
- Sits between the label source and the training/loss datapath, producing target vectors in the same element format the classifier outputs.

## Interface
Parameters:
- `VALUES`, 3: number of classes (vector length); must be ≥ 2.
- `DATA_SIZE`, 8: signed element width.
- `ON_VAL`, 1: signed value emitted at the selected position.
- `OFF_VAL`, 0: signed value emitted at every other position.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_index` in `$clog2(VALUES)`: class index to encode.
- `in_valid` in 1: `in_index` is valid.
- `in_ready` out 1: block can accept an index this cycle.
- `out_data` out signed `DATA_SIZE`: current vector element.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream accepts `out_data`.
- `out_last` out 1: current element is element `VALUES-1`.
- `err` out 1: one-cycle pulse when an accepted index is ≥ `VALUES`.

## Operation
- States:
  - IDLE: no vector in flight.
  - EMIT: streaming elements 0..`VALUES-1`.
- IDLE:
  - `in_ready=1`, `out_valid=0`.
  - `in_valid & in_ready` latches the index, clears element counter `cnt` to 0 and moves to EMIT.
- EMIT:
  - `out_valid=1`.
  - `out_data = (cnt==idx) ? ON_VAL : OFF_VAL`.
  - `out_last = (cnt==VALUES-1)`.
  - On `out_valid & out_ready`, `cnt` increments by 1.
  - On the last beat (`out_last` accepted):
    - if `in_valid`, the new index is accepted in the same cycle (`in_ready=1` only during an accepted last beat), `cnt` returns to 0 and the block stays in EMIT;
    - otherwise the block returns to IDLE.
- `in_ready=0` at all other EMIT cycles.
- Out-of-range index (≥ `VALUES`, possible when `VALUES` is not a power of two):
  - accepted normally;
  - `err` pulses high the cycle after acceptance;
  - the vector is emitted with every element `OFF_VAL`.
- Width rules:
  - `cnt` is `$clog2(VALUES)` bits, compared unsigned against the latched index.
  - `ON_VAL` and `OFF_VAL` are truncated/sign-extended to `DATA_SIZE`; no other arithmetic.
- Backpressure: while `out_valid & ~out_ready`, `out_data`, `out_last` and `cnt` hold stable. An asserted `out_valid` never drops before it is accepted.

## Timing
- Reset (async assert, synchronous deassert): state IDLE, `cnt=0`, latched index 0, `out_valid=0`, `out_last=0`, `out_data=OFF_VAL`, `err=0`, `in_ready=1`.
- Latency: index accepted in cycle N → element 0 valid in cycle N+1.
- Throughput:
  - `VALUES` cycles per vector with `out_ready` held high.
  - Back-to-back vectors have no bubble; element 0 of the next vector is valid the cycle after the previous `out_last` is accepted.
- `err` is registered and asserts in cycle N+1, coincident with element 0.
- Reset mid-vector: the stream is aborted immediately; no `out_last` is emitted and the partial vector is discarded downstream.
- `in_ready` is combinational from state, `cnt` and `out_ready`. `out_*` are register-driven: state, `cnt` and latched index, with no combinational path from `in_*`.

## Structure
- Package `onehot_pkg`:
  - state enum `enc_state_t {IDLE, EMIT}`;
  - default `ON_VAL`/`OFF_VAL` constants;
  - a `CNT_W(values)` width function shared with the argmax block.
- No sub-module; one FSM plus counter fits in a single module.
- A loopback wrapper pairing this block with the argmax block (vector collector + argmax) is the natural verification harness.

## Test plan
- `VALUES=3`, `in_index=1`, `out_ready=1` → beats 0,1,0 on three consecutive cycles starting one cycle after acceptance; `out_last` on beat 3 only; `err=0`.
- `VALUES=3`, `in_index=3` (out of range) → beats 0,0,0; `err` high for exactly one cycle, coincident with element 0.
- Two indices 2 then 0 presented back-to-back, `out_ready=1` → stream 0,0,1,1,0,0 with no idle cycle; `in_ready` high only in IDLE and on each accepted last beat.
- `out_ready` toggled 1,0,0,1,… during index 0 (`ON_VAL=100`, `OFF_VAL=-5`, `DATA_SIZE=8`) → `out_data`/`out_last` stable while stalled; sequence 100,-5,-5 delivered intact.
- `rst_n` pulled low after beat 1 of a 3-beat vector → `out_valid=0`, `in_ready=1` asynchronously; after release, a new index 2 produces 0,0,1 cleanly.
- Loopback through the argmax block, `VALUES=5`, indices 0..4 in sequence (`ON_VAL=1`, `OFF_VAL=0`) → recovered index equals the input index every time.
